spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master controller between NREQ requesters.
// A round-robin arbiter picks one pending requester in IDLE. It then strobes
// the master and waits for MReady_i, or for the timeout, and returns a
// one-cycle Ack_o pulse with the received byte and an error flag.
//
// Ports
//   Clk_i, Rst_i        clock, synchronous active-high reset
//   Req_i[NREQ]         level requests, held until Ack_o
//   Ss_i[2*NREQ]        per-requester one-hot slave select (2 bits each)
//   Data_i[8*NREQ]      per-requester byte to transmit
//   Ack_o[NREQ]         one-cycle completion pulse to the granted requester
//   Err_o, Rdata_o      completion status/byte, valid only with Ack_o
//   Busy_o              high whenever the arbiter is not idle
//   MSs_o, MStrobe_o,
//   MToXmit_o           command side of the SPI master controller
//   MReady_i, MRcvd_i   completion side of the SPI master controller
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 2
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic [NREQ-1:0]   Req_i,
  input  logic [2*NREQ-1:0] Ss_i,
  input  logic [8*NREQ-1:0] Data_i,
  output logic [NREQ-1:0]   Ack_o,
  output logic              Err_o,
  output logic [7:0]        Rdata_o,
  output logic              Busy_o,
  output logic [1:0]        MSs_o,
  output logic              MStrobe_o,
  output logic [7:0]        MToXmit_o,
  input  logic              MReady_i,
  input  logic [7:0]        MRcvd_i
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 16;
  localparam int GW = 4;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic [IW-1:0]   last_grant_reg, last_grant_next;
  logic [1:0]      ss_reg, ss_next;
  logic [7:0]      data_reg, data_next;
  logic            ss_ok_reg, ss_ok_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
  logic            err_reg, err_next;
  logic [7:0]      rdata_reg, rdata_next;

  // Per-requester views of the packed select/data buses.
  logic [1:0] ss_arr   [NREQ];
  logic [7:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign ss_arr[gi]   = Ss_i[2*gi+1 : 2*gi];
    assign data_arr[gi] = Data_i[8*gi+7 : 8*gi];
    assign Ack_o[gi]    = (state_reg == S_DONE) && (grant_reg == IW'(gi));
  end

  // Round-robin search: first requester after last_grant, wrapping at NREQ.
  logic [IW-1:0] win;
  logic [IW-1:0] idx_v;
  logic          found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx_v = last_grant_reg;
    for (int i = 0; i < NREQ; i++) begin
      idx_v = (idx_v == IW'(NREQ - 1)) ? '0 : idx_v + 1'b1;
      if (!found && Req_i[idx_v]) begin
        found = 1'b1;
        win   = idx_v;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    ss_next         = ss_reg;
    data_next       = data_reg;
    ss_ok_next      = ss_ok_reg;
    cnt_next        = cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    err_next        = err_reg;
    rdata_next      = rdata_reg;
    case (state_reg)
      S_IDLE: begin
        if (found) begin
          grant_next = win;
          ss_next    = ss_arr[win];
          data_next  = data_arr[win];
          ss_ok_next = (ss_arr[win] == 2'b01) || (ss_arr[win] == 2'b10);
          state_next = S_STROBE;
        end
      end
      S_STROBE: begin
        // The latched select is judged here: a bad one never reaches the
        // master (strobe and select stay low) and completes with an error.
        cnt_next = '0;
        if (ss_ok_reg) begin
          state_next = S_WAIT;
        end else begin
          err_next   = 1'b1;
          rdata_next = '0;
          state_next = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        // Ready is tested first so it wins over a same-cycle timeout.
        if (MReady_i) begin
          rdata_next = MRcvd_i;
          err_next   = 1'b0;
          state_next = S_DONE;
        end else if (cnt_reg == TO_LAST) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        last_grant_next = grant_reg;
        gap_cnt_next    = '0;
        state_next      = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        gap_cnt_next = gap_cnt_reg + 1'b1;
        if (gap_cnt_reg == GAP_LAST) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_reg      <= S_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= IW'(NREQ - 1);
      ss_reg         <= '0;
      data_reg       <= '0;
      ss_ok_reg      <= 1'b0;
      cnt_reg        <= '0;
      gap_cnt_reg    <= '0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      ss_reg         <= ss_next;
      data_reg       <= data_next;
      ss_ok_reg      <= ss_ok_next;
      cnt_reg        <= cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      err_reg        <= err_next;
      rdata_reg      <= rdata_next;
    end
  end

  // Outputs decode directly from registered state, so they are all zero
  // in the cycle after reset.
  logic xfer;
  assign xfer      = ((state_reg == S_STROBE) || (state_reg == S_WAIT)) && ss_ok_reg;
  assign Busy_o    = (state_reg != S_IDLE);
  assign MStrobe_o = (state_reg == S_STROBE) && ss_ok_reg;
  assign MSs_o     = xfer ? ss_reg : 2'b00;
  assign MToXmit_o = xfer ? data_reg : 8'h00;
  assign Err_o     = (state_reg == S_DONE) ? err_reg : 1'b0;
  assign Rdata_o   = (state_reg == S_DONE) ? rdata_reg : 8'h00;

endmodule
